// File: rtl/adc_sample_framer.sv
// Decimates the offset-binary ADC stream to the sample rate, converts to two's complement,
// and queues samples with frame first/last tags behind a first-word-fall-through valid/ready FIFO.
module adc_sample_framer #(
    parameter int unsigned SAMPLE_BITS = 12,
    parameter int unsigned CLK_DIV     = 3125,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [SAMPLE_BITS-1:0]        adc_in_i,
    input  logic                          clear_overflow_i,
    output logic [SAMPLE_BITS-1:0]        m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_first_o,
    output logic                          m_last_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);

    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned PosW  = $clog2(FRAME_LEN);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned EntW  = SAMPLE_BITS + 2;

    logic [DivW-1:0]  div_cnt_q, div_cnt_d;
    logic [PosW-1:0]  frame_pos_q, frame_pos_d;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [EntW-1:0]  mem_q [FIFO_DEPTH];

    logic            tick, pop, push, drop, full, pos_last;
    logic [EntW-1:0] wr_entry, head;

    always_comb begin
        tick     = enable_i && (div_cnt_q == DivW'(CLK_DIV - 1));
        full     = (count_q == (AddrW + 1)'(FIFO_DEPTH));
        pop      = (count_q != '0) && m_ready_i;
        // A full FIFO still accepts a tick when the head leaves in the same cycle.
        push     = tick && (!full || pop);
        drop     = tick && !push;
        pos_last = (frame_pos_q == PosW'(FRAME_LEN - 1));
        wr_entry = {~adc_in_i[SAMPLE_BITS-1], adc_in_i[SAMPLE_BITS-2:0],
                    (frame_pos_q == '0), pos_last};

        div_cnt_d = '0;
        if (enable_i && !tick) begin
            div_cnt_d = div_cnt_q + DivW'(1);
        end

        frame_pos_d = frame_pos_q;
        if (push) begin
            frame_pos_d = pos_last ? '0 : frame_pos_q + PosW'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AddrW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AddrW + 1)'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q   <= '0;
            frame_pos_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            frame_pos_q <= frame_pos_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head         = mem_q[rd_ptr_q];
        m_valid_o    = (count_q != '0);
        m_data_o     = m_valid_o ? head[EntW-1:2] : '0;
        m_first_o    = m_valid_o && head[1];
        m_last_o     = m_valid_o && head[0];
        overflow_o   = overflow_q;
        fill_level_o = count_q;
    end

endmodule
